// File: rtl/alu_operand_stage.sv
// Operand-fetch/issue stage feeding the ALU: 2R/1W register file with writeback
// bypass, immediate select and a one-entry valid/ready output register.
module alu_operand_stage #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  logic [CTRL_W-1:0] in_alu_ctrl,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_a,
  output logic [XLEN-1:0]   out_b,
  output logic [CTRL_W-1:0] out_alu_ctrl,
  output logic [ADDR_W-1:0] out_rd
);

  localparam int NREG = 2 ** ADDR_W;

  logic [XLEN-1:0]   rf_q [NREG];

  logic              valid_q,   valid_d;
  logic [XLEN-1:0]   a_q,       a_d;
  logic [XLEN-1:0]   b_q,       b_d;
  logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
  logic [ADDR_W-1:0] rd_q,      rd_d;
  logic [ADDR_W-1:0] rs1_q,     rs1_d;
  logic [ADDR_W-1:0] rs2_q,     rs2_d;
  logic              use_imm_q, use_imm_d;

  logic              wb_hit;
  logic              accept;
  logic [XLEN-1:0]   rs1_val;
  logic [XLEN-1:0]   rs2_val;

  assign wb_hit   = wb_en && (wb_rd != '0);
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // x0 is hardwired; a same-cycle writeback wins over the stored value
  assign rs1_val = (in_rs1 == '0)                   ? '0      :
                   (wb_hit && (wb_rd == in_rs1))    ? wb_data : rf_q[in_rs1];
  assign rs2_val = (in_rs2 == '0)                   ? '0      :
                   (wb_hit && (wb_rd == in_rs2))    ? wb_data : rf_q[in_rs2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_hit) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    valid_d   = valid_q;
    a_d       = a_q;
    b_d       = b_q;
    ctrl_d    = ctrl_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    use_imm_d = use_imm_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      a_d       = rs1_val;
      b_d       = in_use_imm ? in_imm : rs2_val;
      ctrl_d    = in_alu_ctrl;
      rd_d      = in_rd;
      rs1_d     = in_rs1;
      rs2_d     = in_rs2;
      use_imm_d = in_use_imm;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // Stalled: track writebacks so the held operands never go stale
      if (wb_hit && (wb_rd == rs1_q)) a_d = wb_data;
      if (wb_hit && (wb_rd == rs2_q) && !use_imm_q) b_d = wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      ctrl_q    <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      use_imm_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ctrl_q    <= ctrl_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      use_imm_q <= use_imm_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_a        = a_q;
  assign out_b        = b_q;
  assign out_alu_ctrl = ctrl_q;
  assign out_rd       = rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: vector table, directed stall/flush/reset
// sequences and a randomized run against an architectural register model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [3:0]  in_alu_ctrl;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b;
  logic [3:0]  out_alu_ctrl;
  logic [4:0]  out_rd;

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(32), .ADDR_W(5), .CTRL_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_alu_ctrl(in_alu_ctrl),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_alu_ctrl(out_alu_ctrl), .out_rd(out_rd)
  );

  int n_pass = 0;
  int n_tot  = 0;

  // Architectural model: register contents plus the one op the ALU sees.
  // Held operands always equal the current register value of their source.
  logic [31:0] mem [32];
  logic        ev;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic        e_ui;
  logic [31:0] e_imm;
  logic [3:0]  e_ctrl;

  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        iv;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        ui;
    logic [3:0]  ctrl;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic [31:0] ea, eb;
    logic [3:0]  ec;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(int wen, int wrd, int wd, int iv, int rs1, int rs2,
                              int rd, int imm, int ui, int ctrl, int ordy, int fl,
                              int xv, int xa, int xb, int xc);
    vec_t v;
    v.wb_en = 1'(wen);  v.wb_rd = 5'(wrd); v.wb_data = 32'(wd);
    v.iv    = 1'(iv);   v.rs1   = 5'(rs1); v.rs2     = 5'(rs2);
    v.rd    = 5'(rd);   v.imm   = 32'(imm); v.ui     = 1'(ui);
    v.ctrl  = 4'(ctrl); v.ordy  = 1'(ordy); v.fl     = 1'(fl);
    v.ev    = 1'(xv);   v.ea    = 32'(xa); v.eb      = 32'(xb);
    v.ec    = 4'(xc);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at %0t",
                  name, act, act, exp, exp, $time);
  endtask

  function automatic logic [31:0] rdreg(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : mem[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    ev = 1'b0;
  endtask

  task automatic model_edge();
    logic acc;
    acc = in_valid && (!ev || out_ready) && !flush;
    if (wb_en && wb_rd != 5'd0) mem[wb_rd] = wb_data;
    if (flush) ev = 1'b0;
    else if (acc) begin
      ev = 1'b1; e_rs1 = in_rs1; e_rs2 = in_rs2; e_rd = in_rd;
      e_ui = in_use_imm; e_imm = in_imm; e_ctrl = in_alu_ctrl;
    end else if (ev && out_ready) ev = 1'b0;
  endtask

  // Inputs are already driven; check handshake, clock once, check outputs.
  task automatic cyc();
    #1;
    chk("in_ready", 32'(in_ready), 32'(!ev || out_ready));
    @(posedge clk);
    model_edge();
    #1;
    chk("out_valid", 32'(out_valid), 32'(ev));
    if (ev) begin
      chk("out_a", out_a, rdreg(e_rs1));
      chk("out_b", out_b, e_ui ? e_imm : rdreg(e_rs2));
      chk("out_alu_ctrl", 32'(out_alu_ctrl), 32'(e_ctrl));
      chk("out_rd", 32'(out_rd), 32'(e_rd));
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_imm = 0;
    in_use_imm = 0; in_alu_ctrl = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic issue(input int rs1, input int rs2, input int rd, input int ctrl, input int ordy);
    in_valid = 1; in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_rd = 5'(rd);
    in_use_imm = 0; in_imm = 0; in_alu_ctrl = 4'(ctrl); out_ready = 1'(ordy);
  endtask

  task automatic wb(input int rd, input int data);
    wb_en = 1; wb_rd = 5'(rd); wb_data = 32'(data);
  endtask

  initial begin
    tbl[0]  = mk(1, 1, 5,   0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0,  0,  0);
    tbl[1]  = mk(1, 2, 10,  0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0,  0,  0);
    tbl[2]  = mk(0, 0, 0,   1, 1, 2, 9,  0, 0, 0, 1, 0, 1, 5,  10, 0);
    tbl[3]  = mk(1, 3, 7,   1, 3, 0, 3,  7, 1, 1, 1, 0, 1, 7,  7,  1);
    tbl[4]  = mk(1, 0, 99,  1, 0, 0, 1,  0, 0, 0, 1, 0, 1, 0,  0,  0);
    tbl[5]  = mk(0, 0, 0,   1, 0, 0, 2,  0, 0, 2, 1, 0, 1, 0,  0,  2);
    tbl[6]  = mk(1, 5, 5,   0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0,  0,  0);
    tbl[7]  = mk(1, 6, 10,  0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0,  0,  0);
    tbl[8]  = mk(0, 0, 0,   1, 5, 6, 10, 0, 0, 4, 1, 0, 1, 5,  10, 4);
    tbl[9]  = mk(0, 0, 0,   1, 1, 3, 11, 0, 0, 0, 1, 0, 1, 5,  7,  0);
    tbl[10] = mk(0, 0, 0,   1, 2, 0, 12, 0, 0, 1, 1, 0, 1, 10, 0,  1);
    tbl[11] = mk(0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0,  0,  0);
    tbl[12] = mk(1, 7, 33,  1, 7, 7, 13, 0, 0, 0, 1, 0, 1, 33, 33, 0);
    tbl[13] = mk(1, 0, 55,  1, 0, 0, 14, 0, 0, 0, 1, 0, 1, 0,  0,  0);
    tbl[14] = mk(0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0,  0,  0);

    idle_inputs();
    model_reset();
    rst = 1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    chk("rst_out_ctrl", 32'(out_alu_ctrl), 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 0;

    for (int i = 0; i < 15; i++) begin
      wb_en = tbl[i].wb_en; wb_rd = tbl[i].wb_rd; wb_data = tbl[i].wb_data;
      in_valid = tbl[i].iv; in_rs1 = tbl[i].rs1; in_rs2 = tbl[i].rs2;
      in_rd = tbl[i].rd; in_imm = tbl[i].imm; in_use_imm = tbl[i].ui;
      in_alu_ctrl = tbl[i].ctrl; out_ready = tbl[i].ordy; flush = tbl[i].fl;
      cyc();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_a", i), out_a, tbl[i].ea);
        chk($sformatf("vec%0d_b", i), out_b, tbl[i].eb);
        chk($sformatf("vec%0d_ctrl", i), 32'(out_alu_ctrl), 32'(tbl[i].ec));
        chk($sformatf("vec%0d_rd", i), 32'(out_rd), 32'(tbl[i].rd));
      end
    end

    // Stall with operand refresh on both A and B
    idle_inputs(); wb(4, 1); cyc();
    idle_inputs(); issue(4, 1, 4, 0, 0); cyc();
    chk("stall_a_init", out_a, 32'd1);
    chk("stall_b_init", out_b, 32'd5);
    idle_inputs(); issue(2, 2, 8, 1, 0); wb(4, 20); cyc();
    chk("stall_a_refresh", out_a, 32'd20);
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    idle_inputs(); out_ready = 0; wb(1, 77); cyc();
    chk("stall_b_refresh", out_b, 32'd77);
    chk("stall_rd_held", 32'(out_rd), 32'd4);
    idle_inputs(); out_ready = 0; wb(0, 123); cyc();
    chk("stall_x0_no_refresh", out_a, 32'd20);
    idle_inputs(); out_ready = 1; #1;
    chk("unstall_in_ready", 32'(in_ready), 32'd1);
    cyc();
    chk("consumed_valid", 32'(out_valid), 32'd0);

    // Flush while stalled drops the held op and the incoming one
    idle_inputs(); issue(2, 3, 15, 0, 0); cyc();
    idle_inputs(); issue(5, 6, 16, 4, 0); flush = 1; cyc();
    chk("flush_valid", 32'(out_valid), 32'd0);
    idle_inputs(); out_ready = 0; #1;
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    cyc();
    chk("flush_no_capture", 32'(out_valid), 32'd0);

    // Reset mid-stall; writeback during reset must not land
    idle_inputs(); issue(1, 2, 17, 0, 0); cyc();
    idle_inputs(); out_ready = 0; rst = 1; wb(1, 123);
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_a", out_a, 32'd0);
    model_reset();
    @(posedge clk); #1;
    wb_en = 0; rst = 0;
    idle_inputs(); issue(1, 2, 18, 0, 1); cyc();
    chk("rst_x1_cleared", out_a, 32'd0);
    chk("rst_x2_cleared", out_b, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      wb_en       = ($urandom_range(0, 1) == 1);
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      in_valid    = ($urandom_range(0, 9) < 6);
      in_rs1      = 5'($urandom_range(0, 7));
      in_rs2      = 5'($urandom_range(0, 7));
      in_rd       = 5'($urandom_range(0, 31));
      in_imm      = $urandom;
      in_use_imm  = ($urandom_range(0, 3) == 0);
      in_alu_ctrl = 4'($urandom_range(0, 15));
      out_ready   = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 15) == 0);
      cyc();
    end

    idle_inputs();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch/issue stage directly upstream of the ALU.
- Holds the 32-entry integer register file and reads rs1/rs2, with write-to-read bypass from writeback.
- Selects the immediate for B and registers A, B, ALUControl and rd into a one-entry valid/ready pipeline register whose outputs drive the ALU inputs.
- Refreshes held operands while stalled so the ALU never consumes stale register values.

Parameters:
- XLEN, 32, datapath width; A/B width to the ALU.
- ADDR_W, 5, register index width; the file has 2**ADDR_W entries.
- CTRL_W, 4, ALUControl width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  issue request valid
- in_ready  out  1  stage can accept an issue this cycle
- in_rs1  in  ADDR_W  source register 1, drives A
- in_rs2  in  ADDR_W  source register 2, drives B when in_use_imm=0
- in_rd  in  ADDR_W  destination register, passed through
- in_imm  in  XLEN  pre-extended immediate
- in_use_imm  in  1  1: B=in_imm; 0: B=reg[rs2]
- in_alu_ctrl  in  CTRL_W  ALU operation (0000 ADD, 0001 SUB, 0100 SLT, ...)
- wb_en  in  1  writeback write enable
- wb_rd  in  ADDR_W  writeback register index
- wb_data  in  XLEN  writeback data
- flush  in  1  kill held and incoming issue
- out_valid  out  1  ALU operands valid
- out_ready  in  1  downstream consumes this cycle
- out_a  out  XLEN  ALU operand A
- out_b  out  XLEN  ALU operand B
- out_alu_ctrl  out  CTRL_W  ALUControl to the ALU
- out_rd  out  ADDR_W  destination register

Behaviour:
- Reset (async, immediate on rst=1):
  - All registers = 0.
  - out_valid = 0; out_a, out_b, out_alu_ctrl, out_rd = 0.
  - wb writes are ignored while rst=1.
- Register file:
  - Write at posedge when wb_en=1 and wb_rd!=0.
  - x0 always reads 0; writes to x0 are dropped.
- Read bypass (combinational):
  - If wb_en=1, wb_rd==rsN and rsN!=0, the read of rsN returns wb_data; otherwise it returns the stored value.
- Handshake:
  - in_ready = !out_valid || out_ready. It is combinational and does not depend on in_valid.
  - Accept = in_valid && in_ready && !flush.
- Posedge update, highest priority first:
  1. flush=1: out_valid<=0. No accept. wb writes still commit.
  2. Accept: load out_a=rd(rs1), out_b=in_use_imm?in_imm:rd(rs2), out_alu_ctrl, out_rd; latch rs1, rs2 and use_imm internally; out_valid<=1.
  3. out_valid && out_ready, with no accept: out_valid<=0. The data registers hold their values.
  4. out_valid && !out_ready (stall): if wb_en && wb_rd!=0 && wb_rd==held rs1, out_a<=wb_data. If the same holds for held rs2 and held use_imm=0, out_b<=wb_data.
- Latency:
  - Accept in cycle N gives out_valid=1 from cycle N+1.
  - Throughput is 1 per cycle when out_ready=1 (back-to-back accept and consume).
- Boundaries:
  - rs1==rs2 with a bypass hit: both A and B take wb_data.
  - wb_rd=0: no write, no bypass, no refresh.
  - Accept and a same-cycle wb to the same source: the bypassed value is captured, so the stage is never one value stale.
  - out_ready while out_valid=0 has no effect.
  - flush while stalled drops the held op. in_ready=1 next cycle.
  - rst mid-stall drops the held op and clears the file.
  - Outputs are registered only. No combinational path from in_* to out_*.

Test Plan:
1. Reset, then write x1=5 and x2=10 via wb; issue rs1=1, rs2=2, ctrl=0000, out_ready=1 → next cycle out_valid=1, out_a=5, out_b=10, out_alu_ctrl=0000. The downstream ALU Result is 15.
2. Same cycle: wb_en=1, wb_rd=3, wb_data=7, plus issue rs1=3, use_imm=1, imm=7, ctrl=0001 → out_a=7 (bypass), out_b=7. ALU Zero=1.
3. Write x0=99; issue rs1=0, rs2=0 → out_a=0, out_b=0. A later read of x0 is still 0.
4. Issue rs1=4 (x4=1) with out_ready=0 held for 3 cycles; write x4=20 during the stall → out_a becomes 20 with out_valid still 1. in_ready=0 throughout. After out_ready=1, in_ready=1.
5. Back-to-back issues with out_ready=1: three ops in 3 cycles → three consecutive out_valid cycles in order. SLT case: x5=5, x6=10, ctrl=0100 → out_a=5, out_b=10.
6. Held op with out_ready=0, then flush=1 plus a new in_valid → next cycle out_valid=0 and the new op is not captured. Assert rst mid-operation → out_valid=0, and reads of x1 return 0.
